// File: rtl/alu_sel_pkg.sv
// Shared types and helpers for the ALU result selector pipeline.
// The optional zero flag is enabled by defining ALU_SEL_ZFLAG_EN.
package alu_sel_pkg;

  // Upper bound on the number of function inputs the selector supports.
  localparam int MAX_FUNC = 64;

  // Occupancy of the two-entry output buffer (main register + skid register).
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_e;

  // Select width for n function inputs; never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/alu_sel_mux.sv
// Combinational NUM_FUNC:1 result mux. A select value with no matching
// function input yields a zero result with the error bit set.
// Output packing: sel_out = {err, result}.
module alu_sel_mux
  import alu_sel_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int NUM_FUNC = 16,
  parameter int SEL_W    = sel_width(NUM_FUNC)
) (
  input  logic [NUM_FUNC*WIDTH-1:0] func_bus,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH:0]            sel_out
);

  // Reject configurations outside the supported range at elaboration.
  if (NUM_FUNC < 2 || NUM_FUNC > MAX_FUNC) begin : g_bad_num_func
    $error("alu_sel_mux: NUM_FUNC must lie in 2..%0d", MAX_FUNC);
  end

  // Linear compare-and-select; an unmatched select falls through to {1, 0}.
  always_comb begin
    sel_out = {1'b1, {WIDTH{1'b0}}};
    for (int k = 0; k < NUM_FUNC; k++) begin
      if (int'(sel) == k) begin
        sel_out = {1'b0, func_bus[k*WIDTH +: WIDTH]};
      end
    end
  end

endmodule

// File: rtl/alu_result_sel_pipe.sv
// ALU result selector with a registered valid/ready output stage.
// The selected result is held in a main register that drives the outputs,
// backed by one skid register so in_ready can be a flop without losing
// throughput. Defining ALU_SEL_ZFLAG_EN adds a per-entry zero flag on
// out_zero; otherwise out_zero is tied low.
module alu_result_sel_pipe
  import alu_sel_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int NUM_FUNC = 16,
  parameter int SEL_W    = sel_width(NUM_FUNC)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_FUNC*WIDTH-1:0] func_bus,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_err,
  output logic                      out_zero,
  output logic                      out_valid,
  input  logic                      out_ready
);

  // Buffer entry layout: {[zero,] err, data}.
`ifdef ALU_SEL_ZFLAG_EN
  localparam int ENT_W = WIDTH + 2;
`else
  localparam int ENT_W = WIDTH + 1;
`endif

  logic [WIDTH:0]   mux_out;
  logic [ENT_W-1:0] in_entry;

  buf_state_e       state_q, state_d;
  logic [ENT_W-1:0] main_q, main_d;
  logic [ENT_W-1:0] skid_q, skid_d;
  logic             in_ready_q, in_ready_d;

  logic             accept;
  logic             deliver;

  alu_sel_mux #(
    .WIDTH    (WIDTH),
    .NUM_FUNC (NUM_FUNC),
    .SEL_W    (SEL_W)
  ) u_mux (
    .func_bus (func_bus),
    .sel      (sel),
    .sel_out  (mux_out)
  );

  // The zero flag is evaluated before the register so it travels with its word.
`ifdef ALU_SEL_ZFLAG_EN
  assign in_entry = {(mux_out[WIDTH-1:0] == '0), mux_out};
  assign out_zero = main_q[WIDTH+1];
`else
  assign in_entry = mux_out;
  assign out_zero = 1'b0;
`endif

  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q[WIDTH-1:0];
  assign out_err   = main_q[WIDTH];
  assign in_ready  = in_ready_q;

  assign accept  = in_valid & in_ready_q;
  assign deliver = out_valid & out_ready;

  // Buffer occupancy transitions and data movement between skid and main.
  always_comb begin
    // NOTE: every signal gets its hold value first, so no branch can leave one unassigned and infer a latch.
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          main_d  = in_entry;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && deliver) begin
          // Main drains and reloads in the same cycle; skid stays idle.
          main_d = in_entry;
        end else if (accept) begin
          skid_d  = in_entry;
          state_d = TWO;
        end else if (deliver) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        // in_ready is low here, so only a delivery can occur.
        if (deliver) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    in_ready_d = (state_d != TWO);
  end

  // State, ready and buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      // NOTE: the data registers are reset too because out_data/out_err/out_zero must read 0 straight out of reset.
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
    end
  end

endmodule

// File: tb/tb_alu_result_sel_pipe.sv
// Scoreboard bench for alu_result_sel_pipe (NUM_FUNC=10 so illegal selects exist).
module tb_alu_result_sel_pipe;

  localparam int W  = 32;
  localparam int NF = 10;
  localparam int SW = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NF*W-1:0] func_bus;
  logic [SW-1:0]   sel;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    out_data;
  logic            out_err;
  logic            out_zero;
  logic            out_valid;
  logic            out_ready;

  always #5 clk = ~clk;

  alu_result_sel_pipe #(
    .WIDTH    (W),
    .NUM_FUNC (NF)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .func_bus  (func_bus),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .out_zero  (out_zero),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  typedef struct packed {
    logic [W-1:0] data;
    logic         err;
    logic         zero;
  } exp_t;

  exp_t         sb_q[$];
  logic [W-1:0] func_arr[NF];
  int           n_cmp = 0;
  int           n_bad = 0;
  logic         rnd_done;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: pick F[s] when it exists, otherwise a zero result flagged as error.
  function automatic exp_t model(input int s);
    exp_t e;
    if (s < NF) begin
      e.data = func_arr[s];
      e.err  = 1'b0;
    end else begin
      e.data = '0;
      e.err  = 1'b1;
    end
`ifdef ALU_SEL_ZFLAG_EN
    e.zero = (e.data == '0);
`else
    e.zero = 1'b0;
`endif
    return e;
  endfunction

  task automatic pack_funcs();
    for (int k = 0; k < NF; k++) func_bus[k*W +: W] = func_arr[k];
  endtask

  // Offer one word; push its expected result once the handshake is seen.
  task automatic send(input int s);
    logic accepted;
    accepted = 1'b0;
    sel = SW'(s);
    pack_funcs();
    in_valid = 1'b1;
    for (int t = 0; t < 1000 && !accepted; t++) begin
      @(negedge clk);
      if (in_ready) begin
        sb_q.push_back(model(s));
        accepted = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!accepted) check("send_timeout", 64'(accepted), 64'd1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: occupancy-based handshake checks, output ordering and stall stability.
  int          occ = 0;
  logic        hold = 1'b0;
  logic [W+1:0] held;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      occ  = 0;
      hold = 1'b0;
    end else begin
      check("out_valid", 64'(out_valid), 64'(occ > 0));
      check("in_ready", 64'(in_ready), 64'(occ < 2));
      if (hold) check("stall_stable", 64'({out_data, out_err, out_zero}), 64'(held));
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_output", 64'(sb_q.size()), 64'd1);
        end else begin
          e = sb_q.pop_front();
          check("out_data", 64'(out_data), 64'(e.data));
          check("out_err", 64'(out_err), 64'(e.err));
          check("out_zero", 64'(out_zero), 64'(e.zero));
        end
      end
      hold = out_valid && !out_ready;
      held = {out_data, out_err, out_zero};
      if (in_valid && in_ready) occ++;
      if (out_valid && out_ready) occ--;
    end
  end

  initial begin
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sel       = '0;
    rnd_done  = 1'b0;
    for (int k = 0; k < NF; k++) func_arr[k] = '0;
    pack_funcs();

    // Power-on reset values.
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_data", 64'(out_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full throughput, selects 0..15 (10..15 illegal here).
    out_ready = 1'b1;
    for (int k = 0; k < NF; k++) func_arr[k] = W'(k * 'h11);
    for (int s = 0; s < 16; s++) send(s);
    idle(3);

    // Backpressure: two accepted, third held until the sink releases.
    out_ready = 1'b0;
    fork
      begin
        send(1);
        send(2);
        send(3);
      end
      begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        check("bp_head_data", 64'(out_data), 64'h11);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    idle(4);

    // Illegal versus last legal select.
    func_arr[9] = 32'hDEAD_BEEF;
    send(12);
    send(9);
    idle(3);

    // Zero result and non-zero result from the same function input.
    func_arr[3] = '0;
    send(3);
    func_arr[3] = 32'd1;
    send(3);
    idle(3);

    // Asynchronous reset while both entries are full.
    out_ready = 1'b0;
    send(4);
    send(5);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_out_data", 64'(out_data), 64'd0);
    check("midrst_out_err", 64'(out_err), 64'd0);
    check("midrst_out_zero", 64'(out_zero), 64'd0);
    sb_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Random traffic with random sink backpressure.
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          if ($urandom_range(0, 3) == 0) idle(1);
          for (int k = 0; k < NF; k++)
            func_arr[k] = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom());
          send(int'($urandom_range(0, 15)));
        end
        in_valid = 1'b0;
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 9) < 7);
        end
      end
    join

    // Drain whatever is still buffered.
    out_ready = 1'b1;
    for (int t = 0; t < 50 && sb_q.size() != 0; t++) @(posedge clk);
    @(posedge clk);
    #1;
    check("drain_empty", 64'(sb_q.size()), 64'd0);
    check("drain_out_valid", 64'(out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
